// File: rtl/spi_arbiter_if.sv
// rtl/spi_arbiter_if.sv - requester and SPI-master signal bundle for spi_arbiter
interface spi_arbiter_if;
    logic [1:0] req_i;
    logic [1:0] last_i;
    logic [7:0] tx_byte0_i;
    logic [7:0] tx_byte1_i;
    logic [1:0] gnt_o;
    logic [1:0] done_o;
    logic [7:0] rx_byte_o;
    logic [1:0] err_o;
    logic [1:0] cs_n_o;
    logic       spi_tx_en_o;
    logic [7:0] spi_tx_byte_o;
    logic [7:0] spi_rx_byte_i;
    logic       spi_done_i;

    modport slave (
        input  req_i, last_i, tx_byte0_i, tx_byte1_i, spi_rx_byte_i, spi_done_i,
        output gnt_o, done_o, rx_byte_o, err_o, cs_n_o, spi_tx_en_o, spi_tx_byte_o
    );

    modport master (
        output req_i, last_i, tx_byte0_i, tx_byte1_i, spi_rx_byte_i, spi_done_i,
        input  gnt_o, done_o, rx_byte_o, err_o, cs_n_o, spi_tx_en_o, spi_tx_byte_o
    );
endinterface

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - two-requester round-robin SPI bus arbiter with frame lock and timeout
module spi_arbiter #(
    parameter int CS_SETUP_CYCLES = 2,
    parameter int CS_HOLD_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input  logic          pllClk_i,
    input  logic          Rst_i_n,
    spi_arbiter_if.slave  bus_io
);

    localparam int MAX_SH  = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
    localparam int MAX_CNT = (TIMEOUT_CYCLES > MAX_SH) ? TIMEOUT_CYCLES : MAX_SH;
    localparam int CW      = $clog2(MAX_CNT);

    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, GAP, HOLD} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_gnt_q, last_gnt_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tx_en_q, tx_en_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          last_q, last_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;

    logic          owner_req;
    logic          owner_last;
    logic [7:0]    owner_byte;
    logic [1:0]    owner_oh;

    assign owner_req  = bus_io.req_i[owner_q];
    assign owner_last = bus_io.last_i[owner_q];
    assign owner_byte = owner_q ? bus_io.tx_byte1_i : bus_io.tx_byte0_i;
    assign owner_oh   = owner_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        tx_en_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        rx_byte_d  = rx_byte_q;
        last_d     = last_q;
        done_d     = 2'b00;
        err_d      = 2'b00;
        case (state_q)
            IDLE: begin
                if (|bus_io.req_i) begin
                    owner_d = (bus_io.req_i == 2'b11) ? ~last_gnt_q : bus_io.req_i[1];
                    gnt_d   = owner_d ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    tx_en_d   = 1'b1;
                    tx_byte_d = owner_byte;
                    last_d    = owner_last;
                    cnt_d     = '0;
                    state_d   = XFER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus_io.spi_done_i) begin
                    rx_byte_d = bus_io.spi_rx_byte_i;
                    done_d    = owner_oh;
                    cnt_d     = '0;
                    state_d   = last_q ? HOLD : GAP;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = owner_oh;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                // During the done pulse the owner's req_i still belongs to the finished byte.
                if (owner_req && (done_q == 2'b00)) begin
                    tx_en_d   = 1'b1;
                    tx_byte_d = owner_byte;
                    last_d    = owner_last;
                    cnt_d     = '0;
                    state_d   = XFER;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = owner_oh;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    gnt_d      = 2'b00;
                    last_gnt_d = owner_q;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = 2'b00;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pllClk_i) begin
        if (!Rst_i_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            gnt_q      <= 2'b00;
            cnt_q      <= '0;
            tx_en_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            rx_byte_q  <= 8'h00;
            last_q     <= 1'b0;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            tx_en_q    <= tx_en_d;
            tx_byte_q  <= tx_byte_d;
            rx_byte_q  <= rx_byte_d;
            last_q     <= last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus_io.gnt_o         = gnt_q;
    assign bus_io.cs_n_o        = ~gnt_q;
    assign bus_io.done_o        = done_q;
    assign bus_io.err_o         = err_q;
    assign bus_io.rx_byte_o     = rx_byte_q;
    assign bus_io.spi_tx_en_o   = tx_en_q;
    assign bus_io.spi_tx_byte_o = tx_byte_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed self-checking bench for spi_arbiter
module tb_spi_arbiter;
    localparam int SETUP = 2;
    localparam int HOLDC = 2;
    localparam int TMO   = 20;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   lat;
    int   cs0_breaks;
    int   g1_seen;
    int   done_seen;
    logic mon_on;
    logic [7:0] b;

    spi_arbiter_if bus ();

    spi_arbiter #(
        .CS_SETUP_CYCLES (SETUP),
        .CS_HOLD_CYCLES  (HOLDC),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .pllClk_i (clk),
        .Rst_i_n  (rst_n),
        .bus_io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.cs_n_o[0] !== 1'b0) cs0_breaks++;
            if (bus.gnt_o[1] !== 1'b0) g1_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_tx_en(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (bus.spi_tx_en_o === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic byte_xfer(input string tag, input logic [1:0] oh, input logic [7:0] txb, input logic [7:0] rxb);
        int c;
        wait_tx_en(c);
        check({tag, "_started"}, (c > 0), 1);
        check({tag, "_txbyte"}, bus.spi_tx_byte_o, txb);
        tick();
        tick();
        bus.spi_done_i    = 1'b1;
        bus.spi_rx_byte_i = rxb;
        tick();
        bus.spi_done_i    = 1'b0;
        check({tag, "_done"}, bus.done_o, oh);
        check({tag, "_rx"}, bus.rx_byte_o, rxb);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_i = 2'b00;
        bus.spi_done_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        cs0_breaks = 0;
        g1_seen = 0;
        mon_on = 1'b0;
        bus.req_i = 2'b00;
        bus.last_i = 2'b00;
        bus.tx_byte0_i = 8'h00;
        bus.tx_byte1_i = 8'h00;
        bus.spi_rx_byte_i = 8'h00;
        bus.spi_done_i = 1'b0;
        do_reset();

        check("rst_gnt", bus.gnt_o, 2'b00);
        check("rst_cs", bus.cs_n_o, 2'b11);
        check("rst_done", bus.done_o, 2'b00);
        check("rst_err", bus.err_o, 2'b00);
        check("rst_txen", bus.spi_tx_en_o, 1'b0);
        check("rst_txbyte", bus.spi_tx_byte_o, 8'h00);
        check("rst_rx", bus.rx_byte_o, 8'h00);

        // single-byte frame, latency and hold release
        bus.req_i = 2'b01;
        bus.last_i = 2'b01;
        bus.tx_byte0_i = 8'hA5;
        tick();
        check("t1_gnt", bus.gnt_o, 2'b01);
        check("t1_cs", bus.cs_n_o, 2'b10);
        check("t1_txen_early", bus.spi_tx_en_o, 1'b0);
        wait_tx_en(lat);
        check("t1_latency", lat, SETUP);
        check("t1_txbyte", bus.spi_tx_byte_o, 8'hA5);
        tick();
        check("t1_txen_pulse", bus.spi_tx_en_o, 1'b0);
        repeat (6) tick();
        bus.spi_done_i = 1'b1;
        bus.spi_rx_byte_i = 8'h3C;
        tick();
        bus.spi_done_i = 1'b0;
        bus.req_i = 2'b00;
        check("t1_done", bus.done_o, 2'b01);
        check("t1_err", bus.err_o, 2'b00);
        check("t1_rx", bus.rx_byte_o, 8'h3C);
        tick();
        check("t1_hold_cs", bus.cs_n_o, 2'b10);
        check("t1_done_pulse", bus.done_o, 2'b00);
        tick();
        check("t1_release_cs", bus.cs_n_o, 2'b11);
        check("t1_release_gnt", bus.gnt_o, 2'b00);

        // round robin on simultaneous requests after reset
        do_reset();
        for (int i = 0; i < 3; i++) begin
            logic [1:0] exp_g;
            exp_g = (i == 1) ? 2'b10 : 2'b01;
            bus.req_i = 2'b11;
            bus.last_i = 2'b11;
            bus.tx_byte0_i = 8'h10 + 8'(i);
            bus.tx_byte1_i = 8'h20 + 8'(i);
            tick();
            check($sformatf("t2_gnt%0d", i), bus.gnt_o, exp_g);
            b = (i == 1) ? bus.tx_byte1_i : bus.tx_byte0_i;
            byte_xfer($sformatf("t2_b%0d", i), exp_g, b, 8'h50 + 8'(i));
            bus.req_i = 2'b00;
            tick();
            tick();
            check($sformatf("t2_idle%0d", i), bus.cs_n_o, 2'b11);
        end

        // three-byte frame lock against a competing requester
        bus.req_i = 2'b01;
        bus.last_i = 2'b00;
        bus.tx_byte0_i = 8'h11;
        tick();
        check("t3_gnt0", bus.gnt_o, 2'b01);
        mon_on = 1'b1;
        bus.req_i = 2'b11;
        bus.tx_byte1_i = 8'h99;
        bus.last_i = 2'b10;
        byte_xfer("t3_b1", 2'b01, 8'h11, 8'hA1);
        bus.tx_byte0_i = 8'h22;
        byte_xfer("t3_b2", 2'b01, 8'h22, 8'hA2);
        bus.tx_byte0_i = 8'h33;
        bus.last_i = 2'b11;
        byte_xfer("t3_b3", 2'b01, 8'h33, 8'hA3);
        bus.req_i = 2'b10;
        tick();
        mon_on = 1'b0;
        tick();
        check("t3_idle_gnt", bus.gnt_o, 2'b00);
        check("t3_idle_cs", bus.cs_n_o, 2'b11);
        tick();
        check("t3_gnt1", bus.gnt_o, 2'b10);
        check("t3_cs0_low", cs0_breaks, 0);
        check("t3_no_gnt1_early", g1_seen, 0);
        byte_xfer("t3_r1", 2'b10, 8'h99, 8'hB1);
        bus.req_i = 2'b00;
        tick();
        tick();
        check("t3_end_cs", bus.cs_n_o, 2'b11);

        // timeout with no spi_done_i
        bus.req_i = 2'b01;
        bus.last_i = 2'b01;
        bus.tx_byte0_i = 8'hC3;
        wait_tx_en(lat);
        check("t4_started", (lat > 0), 1);
        done_seen = 0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (bus.done_o !== 2'b00) done_seen++;
            if (bus.err_o !== 2'b00) begin
                lat = i;
                break;
            end
        end
        bus.req_i = 2'b00;
        check("t4_err_time", lat, TMO + 1);
        check("t4_err", bus.err_o, 2'b01);
        check("t4_no_done", done_seen, 0);
        tick();
        check("t4_err_pulse", bus.err_o, 2'b00);
        tick();
        check("t4_release", bus.cs_n_o, 2'b11);

        // spi_done_i on the expiry cycle: done wins
        bus.req_i = 2'b10;
        bus.last_i = 2'b10;
        bus.tx_byte1_i = 8'hE7;
        wait_tx_en(lat);
        check("t5_started", (lat > 0), 1);
        repeat (TMO) tick();
        check("t5_no_early_err", bus.err_o, 2'b00);
        bus.spi_done_i = 1'b1;
        bus.spi_rx_byte_i = 8'h6B;
        tick();
        bus.spi_done_i = 1'b0;
        bus.req_i = 2'b00;
        check("t5_done", bus.done_o, 2'b10);
        check("t5_no_err", bus.err_o, 2'b00);
        check("t5_rx", bus.rx_byte_o, 8'h6B);
        tick();
        check("t5_no_err_late", bus.err_o, 2'b00);
        tick();
        check("t5_release", bus.cs_n_o, 2'b11);

        // reset during WAIT, later spi_done_i ignored
        bus.req_i = 2'b01;
        bus.last_i = 2'b01;
        bus.tx_byte0_i = 8'h5C;
        wait_tx_en(lat);
        check("t6_started", (lat > 0), 1);
        repeat (3) tick();
        rst_n = 1'b0;
        bus.req_i = 2'b00;
        tick();
        check("t6_gnt", bus.gnt_o, 2'b00);
        check("t6_cs", bus.cs_n_o, 2'b11);
        check("t6_done", bus.done_o, 2'b00);
        check("t6_err", bus.err_o, 2'b00);
        check("t6_txen", bus.spi_tx_en_o, 1'b0);
        check("t6_txbyte", bus.spi_tx_byte_o, 8'h00);
        check("t6_rx", bus.rx_byte_o, 8'h00);
        rst_n = 1'b1;
        tick();
        bus.spi_done_i = 1'b1;
        bus.spi_rx_byte_i = 8'h77;
        tick();
        bus.spi_done_i = 1'b0;
        check("t6_late_done", bus.done_o, 2'b00);
        check("t6_late_rx", bus.rx_byte_o, 8'h00);
        tick();
        check("t6_late_cs", bus.cs_n_o, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter CS_SETUP_CYCLES, default 2, cycles cs_n low before first spi_tx_en_o of a frame (min 1).
REQ-002 Parameter CS_HOLD_CYCLES, default 2, cycles bus stays owned after frame end before release (min 1).
REQ-003 Parameter TIMEOUT_CYCLES, default 1023, max cycles in WAIT or GAP before abort (min 2).
REQ-004 pllClk_i  in  1  system clock; all logic on rising edge.
REQ-005 Rst_i_n  in  1  reset; one clock, synchronous and active-low.
REQ-006 req_i  in  2  per-requester byte-transfer request, held until matching done_o/err_o.
REQ-007 last_i  in  2  per-requester: current byte ends the frame; valid while req_i high.
REQ-008 tx_byte0_i, tx_byte1_i  in  8 each  byte to send for requester 0/1; stable while req_i high.
REQ-009 gnt_o  out  2  one-hot bus ownership; 0 when idle.
REQ-010 done_o  out  2  one-cycle pulse to owner, byte complete.
REQ-011 rx_byte_o  out  8  received byte, valid in the done_o cycle, held until next capture.
REQ-012 err_o  out  2  one-cycle pulse to owner on timeout abort.
REQ-013 cs_n_o  out  2  active-low slave select, one per requester, equals ~gnt_o during SETUP/XFER/WAIT/GAP.
REQ-014 spi_tx_en_o  out  1  one-cycle start pulse to SPI master.
REQ-015 spi_tx_byte_o  out  8  byte to SPI master, stable from start pulse until spi_done_i.
REQ-016 spi_rx_byte_i  in  8  byte from SPI master, sampled on spi_done_i.
REQ-017 spi_done_i  in  1  SPI master one-cycle byte-complete pulse.

Function
REQ-018 States SHALL be IDLE, SETUP, XFER, WAIT, GAP, HOLD; single registered state.
REQ-019 IDLE: if any req_i, grant by round-robin (requester not granted last wins on tie; requester 0 wins first tie after reset); next cycle gnt_o/cs_n_o asserted, state SETUP, counter loaded.
REQ-020 SETUP lasts exactly CS_SETUP_CYCLES cycles, then XFER.
REQ-021 XFER lasts one cycle: spi_tx_en_o=1, owner tx byte and last_i latched into spi_tx_byte_o / last flag; next WAIT.
REQ-022 Latency: req_i seen at edge k in IDLE -> spi_tx_en_o high in cycle k+1+CS_SETUP_CYCLES.
REQ-023 WAIT: on spi_done_i, rx_byte_o<=spi_rx_byte_i and owner done_o pulses next cycle; go HOLD if latched last, else GAP.
REQ-024 GAP: cs_n stays low; owner req_i -> XFER next cycle (no setup); other requester ignored (frame lock).
REQ-025 WAIT/GAP counter counts from 0; reaching TIMEOUT_CYCLES -> owner err_o pulse, go HOLD; spi_done_i same cycle as expiry: done wins, no err.
REQ-026 HOLD: cs_n stays low CS_HOLD_CYCLES cycles, then gnt_o=0, cs_n_o=2'b11, last-granted recorded, IDLE.
REQ-027 Release-to-regrant: at least one IDLE cycle with cs_n_o=2'b11 between frames.
REQ-028 done_o and err_o SHALL never both pulse; at most one bit set in each.
REQ-029 spi_done_i outside WAIT SHALL be ignored.

Reset
REQ-030 Rst_i_n low at an edge: state IDLE, gnt_o=0, done_o=0, err_o=0, cs_n_o=2'b11, spi_tx_en_o=0, spi_tx_byte_o=0, rx_byte_o=0, counter 0, last-granted=1 (so requester 0 wins first).
REQ-031 Reset mid-frame SHALL release cs_n_o on the next edge with no done_o/err_o.

Verification
REQ-032 req_i=01, last=1, tx_byte0=A5, spi_done_i 8 cycles after start with rx=3C -> spi_tx_en_o at k+3, cs_n_o=10, done_o=01, rx_byte_o=3C, cs_n_o=11 after 2 HOLD cycles.
REQ-033 req_i=11 simultaneous after reset -> gnt 01 first; repeat -> gnt 10; repeat -> gnt 01.
REQ-034 Requester 0 three-byte frame (last on byte 3), requester 1 requesting throughout -> cs_n_o[0] low continuously, gnt_o[1] only after HOLD + one IDLE cycle.
REQ-035 No spi_done_i after start -> err_o=01 exactly TIMEOUT_CYCLES cycles into WAIT, no done_o, bus released.
REQ-036 spi_done_i coincident with timeout expiry -> done_o pulse, no err_o.
REQ-037 Rst_i_n low during WAIT -> next edge all outputs at reset values; later spi_done_i ignored.
